// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and load/store.
// One transaction in flight; data has priority, fetch is protected from starvation.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_we,
    input  logic [31:0]   d_wdata,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_stall,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_we,
    output logic [31:0]   mem_wdata,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t        r_state;
    owner_t        r_owner;
    logic          r_drop;
    logic [3:0]    r_starve;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_we;
    logic [31:0]   r_wdata;

    state_t        w_state_nxt;
    owner_t        w_owner_nxt;
    logic          w_drop_nxt;
    logic [3:0]    w_starve_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic [3:0]    w_we_nxt;
    logic [31:0]   w_wdata_nxt;

    logic w_if_act;
    logic w_grant_f;
    logic w_grant_d;
    logic w_resp;
    logic w_flush_own;

    // A fetch raised together with a redirect is stale and never competes.
    assign w_if_act  = if_req && !if_flush;
    assign w_grant_f = w_if_act && (!d_req || (r_starve == SMAX));
    assign w_grant_d = d_req && !w_grant_f;

    assign w_flush_own = if_flush && (r_owner == OWN_FETCH);

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_drop_nxt   = r_drop;
        w_starve_nxt = r_starve;
        w_addr_nxt   = r_addr;
        w_we_nxt     = r_we;
        w_wdata_nxt  = r_wdata;
        unique case (r_state)
            S_IDLE: begin
                w_drop_nxt = 1'b0;
                if (w_grant_d) begin
                    w_state_nxt = S_ISSUE;
                    w_owner_nxt = OWN_DATA;
                    w_addr_nxt  = d_addr;
                    w_we_nxt    = d_we;
                    w_wdata_nxt = d_wdata;
                    if (w_if_act && (r_starve != SMAX))
                        w_starve_nxt = r_starve + 4'd1;
                end else if (w_grant_f) begin
                    w_state_nxt  = S_ISSUE;
                    w_owner_nxt  = OWN_FETCH;
                    w_addr_nxt   = if_addr;
                    w_we_nxt     = 4'b0000;
                    w_wdata_nxt  = 32'h0;
                    w_starve_nxt = 4'd0;
                end
            end
            S_ISSUE: begin
                if (w_flush_own)
                    w_drop_nxt = 1'b1;
                if (mem_ready)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_flush_own)
                    w_drop_nxt = 1'b1;
                if (mem_rvalid) begin
                    w_state_nxt = S_IDLE;
                    w_drop_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= OWN_FETCH;
            r_drop   <= 1'b0;
            r_starve <= 4'd0;
            r_addr   <= '0;
            r_we     <= 4'b0000;
            r_wdata  <= 32'h0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_drop   <= w_drop_nxt;
            r_starve <= w_starve_nxt;
            r_addr   <= w_addr_nxt;
            r_we     <= w_we_nxt;
            r_wdata  <= w_wdata_nxt;
        end
    end

    assign w_resp = (r_state == S_WAIT) && mem_rvalid;

    // A redirect in the response cycle itself also hides that response.
    assign if_rvalid = w_resp && (r_owner == OWN_FETCH)
                       && !r_drop && !if_flush;
    assign d_rvalid  = w_resp && (r_owner == OWN_DATA);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign if_stall  = if_req && !if_rvalid;
    assign d_stall   = d_req && !d_rvalid;

    assign mem_valid = (r_state == S_ISSUE);
    assign mem_addr  = r_addr;
    assign mem_we    = r_we;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != S_IDLE);

endmodule
